// File: rtl/fetch.sv
// fetch: CHIP-8 instruction fetch unit; owns PC and call stack and assembles
// big-endian opcodes from byte-wide synchronous program RAM.
module fetch #(
  parameter logic [11:0] PC_RESET    = 12'h200,
  parameter int          STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [15:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [11:0] pc,
  input  logic [2:0]  pc_op,
  input  logic [11:0] pc_target,
  input  logic        pc_update,
  output logic        stack_err
);
  localparam int SPW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW:0] SP_FULL = STACK_DEPTH[SPW:0];
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CAP, S_VALID, S_EXEC} state_t;
  state_t state_q, state_d;
  logic [11:0] pc_q, pc_d, pc_inc2;
  logic [SPW:0] sp_q, sp_d;
  logic [15:0] instr_q, instr_d;
  logic err_q, err_d, push, upd, full, empty;
  logic [SPW-1:0] top_idx;
  logic [11:0] stack_q [STACK_DEPTH];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      sp_q    <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end

  // Stack contents need no reset; only sp defines what is live.
  always_ff @(posedge clk)
    if (push) stack_q[sp_q[SPW-1:0]] <= pc_inc2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_HI;
      S_HI:    state_d = S_LO;
      S_LO:    state_d = S_CAP;
      S_CAP:   state_d = S_VALID;
      S_VALID: state_d = instr_ready ? S_EXEC : S_VALID;
      S_EXEC:  state_d = pc_update ? S_HI : S_EXEC;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    upd     = state_q == S_EXEC && pc_update;
    pc_inc2 = pc_q + 12'd2;
    top_idx = sp_q[SPW-1:0] - 1'b1;
    full    = sp_q == SP_FULL;
    empty   = sp_q == '0;
    instr_d = state_q == S_LO  ? {mem_data, instr_q[7:0]} :
              state_q == S_CAP ? {instr_q[15:8], mem_data} : instr_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    if (upd)
      case (pc_op)
        3'd1: pc_d = pc_q + 12'd4;
        3'd2: pc_d = pc_target;
        3'd3: begin
          push  = !full;
          sp_d  = full ? sp_q : sp_q + 1'b1;
          err_d = err_q | full;
          pc_d  = full ? pc_inc2 : pc_target;
        end
        3'd4: begin
          sp_d  = empty ? sp_q : sp_q - 1'b1;
          err_d = err_q | empty;
          pc_d  = empty ? pc_inc2 : stack_q[top_idx];
        end
        default: pc_d = pc_inc2;
      endcase
  end

  always_comb begin
    mem_rd      = state_q == S_HI || state_q == S_LO;
    mem_addr    = state_q == S_HI ? pc_q : state_q == S_LO ? pc_q + 12'd1 : 12'd0;
    instr_valid = state_q == S_VALID;
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign stack_err   = err_q;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch; expected {pc, opcode} pairs are queued
// at each issued PC update and checked by a monitor on every new instr_valid.
module tb_fetch;
  localparam logic [2:0] OP_NEXT = 3'd0, OP_SKIP = 3'd1, OP_JUMP = 3'd2, OP_CALL = 3'd3, OP_RET = 3'd4;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] pc;
  logic [2:0]  pc_op;
  logic [11:0] pc_target;
  logic        pc_update;
  logic        stack_err;

  logic [7:0]  ram [4096];
  logic [27:0] exp_q [$];
  logic [27:0] mon_e;
  logic        prev_v = 1'b0;
  int          errors = 0;
  int          checks = 0;

  fetch dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_op(pc_op), .pc_target(pc_target), .pc_update(pc_update), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("mon_pc", {20'd0, pc}, {20'd0, mon_e[27:16]});
        chk("mon_instr", {16'd0, instruction}, {16'd0, mon_e[15:0]});
      end
    end
    prev_v = instr_valid;
  end

  task automatic expect_fetch(input logic [11:0] a);
    logic [11:0] b;
    b = a + 12'd1;
    exp_q.push_back({a, ram[a], ram[b]});
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Handshake (with a stray pc_update that must be ignored), then the real update.
  task automatic issue(input logic [2:0] op, input logic [11:0] tgt, input logic [11:0] exp_pc);
    instr_ready = 1'b1; pc_update = 1'b1; pc_op = OP_JUMP; pc_target = 12'hABC;
    @(negedge clk);
    chk("exec_valid_low", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b0; pc_update = 1'b1; pc_op = op; pc_target = tgt;
    expect_fetch(exp_pc);
    @(negedge clk);
    pc_update = 1'b0;
  endtask

  task automatic step(input logic [2:0] op, input logic [11:0] tgt, input logic [11:0] exp_pc);
    issue(op, tgt, exp_pc);
    wait_valid("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_pc", {20'd0, pc}, 32'h200);
    chk("rst_err", {31'd0, stack_err}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_fetch(12'h200);
    wait_valid("reset");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + (i >> 8) * 3 + 1);
    ram[12'h200] = 8'h6A; ram[12'h201] = 8'h05;
    ram[12'hFFE] = 8'h12; ram[12'hFFF] = 8'hAB; ram[12'h000] = 8'hCD;
    rst = 1'b1; instr_ready = 1'b0; pc_update = 1'b0; pc_op = OP_NEXT; pc_target = 12'h0;
    // Test 1: reset state, read sequence and first-fetch latency.
    @(negedge clk); @(negedge clk);
    chk("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("t1_rst_pc", {20'd0, pc}, 32'h200);
    expect_fetch(12'h200);
    rst = 1'b0;
    chk("t1_idle_rd", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    chk("t1_hi_rd", {31'd0, mem_rd}, 32'd1);
    chk("t1_hi_addr", {20'd0, mem_addr}, 32'h200);
    @(negedge clk);
    chk("t1_lo_rd", {31'd0, mem_rd}, 32'd1);
    chk("t1_lo_addr", {20'd0, mem_addr}, 32'h201);
    @(negedge clk);
    chk("t1_cap_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", {16'd0, instruction}, 32'h6A05);
    // Test 2: stall with ready low, then NEXT with update-to-valid latency.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_hold_instr", {16'd0, instruction}, 32'h6A05);
    end
    issue(OP_NEXT, 12'h0, 12'h202);
    chk("t2_hi_addr", {20'd0, mem_addr}, 32'h202);
    chk("t2_lat0", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t2_lat1", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t2_lat2", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t2_lat3", {31'd0, instr_valid}, 32'd1);
    // Test 3: SKIP and JUMP.
    step(OP_NEXT, 12'h0, 12'h204);
    step(OP_SKIP, 12'h0, 12'h208);
    step(OP_JUMP, 12'h3F0, 12'h3F0);
    step(OP_JUMP, 12'h210, 12'h210);
    // Test 4: CALL/RET, overflow on the 17th nested CALL.
    step(OP_CALL, 12'h400, 12'h400);
    step(OP_RET, 12'h0, 12'h212);
    chk("t4_err_clear", {31'd0, stack_err}, 32'd0);
    for (int i = 0; i < 16; i++) step(OP_CALL, 12'h600 + 12'(i * 16), 12'h600 + 12'(i * 16));
    chk("t4_err_16", {31'd0, stack_err}, 32'd0);
    step(OP_CALL, 12'h700, 12'h6F2);
    chk("t4_err_17", {31'd0, stack_err}, 32'd1);
    step(OP_RET, 12'h0, 12'h6E2);
    chk("t4_err_sticky", {31'd0, stack_err}, 32'd1);
    // Test 5: PC wrap and lo-byte address wrap.
    step(OP_JUMP, 12'hFFE, 12'hFFE);
    chk("t5_ffe_instr", {16'd0, instruction}, 32'h12AB);
    step(OP_NEXT, 12'h0, 12'h000);
    issue(OP_JUMP, 12'hFFF, 12'hFFF);
    chk("t5_hi_addr", {20'd0, mem_addr}, 32'hFFF);
    @(negedge clk);
    chk("t5_lo_addr", {20'd0, mem_addr}, 32'h000);
    wait_valid("t5");
    chk("t5_fff_instr", {16'd0, instruction}, 32'hABCD);
    // Test 6: reset during S_LO and during S_VALID; RET on empty stack.
    issue(OP_NEXT, 12'h0, 12'h001);
    @(negedge clk);
    chk("t6_in_lo", {20'd0, mem_addr}, 32'h002);
    do_reset();
    chk("t6_valid_before", {31'd0, instr_valid}, 32'd1);
    do_reset();
    chk("t6_restart_instr", {16'd0, instruction}, 32'h6A05);
    step(OP_RET, 12'h0, 12'h202);
    chk("t6_ret_empty_err", {31'd0, stack_err}, 32'd1);
    do_reset();
    step(OP_NEXT, 12'h0, 12'h202);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction fetch unit for the CHIP-8 core. It owns the program counter and the 16-entry call stack, and reads each 2-byte opcode big-endian from the byte-wide program RAM. It presents the assembled 16-bit opcode to the decoder through a valid/ready handshake. After the execute stage reports how the PC must advance, it fetches the next opcode.

Parameters:
PC_RESET, 12'h200, PC value loaded at reset (program start)
STACK_DEPTH, 16, number of return-address entries (power of two, max 16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
mem_addr  output  12  program RAM byte address
mem_rd  output  1  RAM read strobe; data returned on mem_data one cycle later
mem_data  input  8  RAM read data (synchronous, 1-cycle latency)
instruction  output  16  assembled opcode {hi byte, lo byte}, feeds decoder
instr_valid  output  1  instruction holds a fetched opcode
instr_ready  input  1  decoder accepts opcode
pc  output  12  address of the opcode currently held/executing
pc_op  input  3  0 NEXT, 1 SKIP, 2 JUMP, 3 CALL, 4 RET; 5-7 treated as NEXT
pc_target  input  12  target for JUMP/CALL (jump address or V0+nnn, computed by execute)
pc_update  input  1  single-cycle pulse: apply pc_op, start next fetch
stack_err  output  1  sticky: CALL on full stack or RET on empty stack

Behaviour:
- Reset (async, immediate): state=S_IDLE, pc=PC_RESET, sp=0, instruction=0, instr_valid=0, mem_rd=0, mem_addr=0, stack_err=0. Stack contents are don't-care.
- Reset mid-fetch or mid-handshake abandons all work. instr_valid drops at reset assertion, not at the next edge.
- mem_rd and mem_addr are decoded from the state and pc registers:
  - S_HI: mem_rd=1, mem_addr=pc.
  - S_LO: mem_rd=1, mem_addr=pc+1 (mod 4096).
  - Other states: mem_rd=0, mem_addr=0.
- FSM:
  - S_IDLE -> S_HI unconditionally.
  - S_HI -> S_LO.
  - S_LO -> S_CAP. On this edge, capture mem_data into instruction[15:8].
  - S_CAP -> S_VALID. On this edge, capture mem_data into instruction[7:0].
  - S_VALID: instr_valid=1. instruction and pc are stable. On instr_valid && instr_ready -> S_EXEC.
  - S_EXEC: instr_valid=0, instruction held. On pc_update, apply pc_op, then -> S_HI.
- pc_update outside S_EXEC is ignored, including in the handshake cycle.
- Latency: instr_valid rises after the 4th rising edge following reset release. Each subsequent fetch takes 3 cycles from the pc_update edge to instr_valid.
- PC arithmetic is 12-bit modulo 4096, so 0xFFE+2=0x000.
  - NEXT: pc+2.
  - SKIP: pc+4.
  - JUMP: pc_target.
  - CALL: stack[sp]=pc+2, sp++, pc=pc_target.
  - RET: sp--, pc=stack[sp].
- CALL with sp==STACK_DEPTH: no push, stack_err=1, pc=pc+2.
- RET with sp==0: no pop, stack_err=1, pc=pc+2.
- stack_err clears only on reset.
- The lo-byte address wraps: pc=0xFFF reads hi at 0xFFF and lo at 0x000.
- instr_ready while instr_valid=0 has no effect.
- No combinational path from any input to any output.

Test Plan:
1. Reset with RAM[0x200]=0x6A, RAM[0x201]=0x05, release -> mem_rd at 0x200 then 0x201. After 4th edge: instr_valid=1, instruction=0x6A05, pc=0x200.
2. Hold instr_ready=0 for 10 cycles -> instr_valid stays 1 and instruction stable. Then ready=1, then pc_update with pc_op=NEXT -> next fetch at 0x202, valid 3 cycles after the update edge.
3. pc_op=SKIP at pc=0x204 -> next fetch at 0x208. pc_op=JUMP with target 0x3F0 -> fetch at 0x3F0.
4. CALL 0x400 from pc=0x210, then RET -> pc=0x400, then 0x212. Seventeen nested CALLs -> 17th sets stack_err and pc=caller+2. RET with sp=0 -> stack_err=1.
5. JUMP to 0xFFE, NEXT -> pc=0x000. JUMP to 0xFFF -> reads addresses 0xFFF then 0x000.
6. Assert rst during S_LO and during S_VALID -> instr_valid=0 immediately. pc=0x200 on release, and the fetch restarts cleanly.
